// File: rtl/multi_ring_pkg.sv
// -----------------------------------------------------------------------------
// multi_ring_pkg
// Shared definitions for the multi-channel ring-oscillator counter:
//   - state_t / IDLE, GATE, LATCH : measurement FSM state encoding
//   - gate_width(cycles)          : width of a counter running 0..cycles-1
//   - sel_width(ch)               : width of a channel select, never below 1
// No ports (package).
// -----------------------------------------------------------------------------
package multi_ring_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t GATE  = 2'd1;
    localparam state_t LATCH = 2'd2;

    function automatic int gate_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/ring_edge_counter.sv
// -----------------------------------------------------------------------------
// ring_edge_counter
// One measurement channel: synchronises an asynchronous ring-oscillator output,
// detects its rising edges and counts them into a saturating window counter.
// Ports:
//   clk      in  : system clock
//   reset    in  : synchronous, active-high reset
//   ring     in  : asynchronous ring-oscillator output
//   count_en in  : 1 while the gate window is open
//   clear    in  : clears the window counter and saturation flag
//   count    out : edges counted in the current window (saturating)
//   sat      out : an edge arrived while the counter was already at maximum
// -----------------------------------------------------------------------------
import multi_ring_pkg::*;

module ring_edge_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ring,
    input  logic             count_en,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    // Synchroniser chain followed by a registered rising-edge detector, so a
    // ring transition reaches rise_q SYNC_STAGES+1 cycles after it happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ring};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Window counter holds at its maximum; further edges only raise sat.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (count_en && rise_q) begin
            if (count == CNT_MAX) begin
                sat <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_ring_counter.sv
// -----------------------------------------------------------------------------
// multi_ring_counter
// Counts rising edges of CH ring oscillators over a GATE_CYCLES-long gate
// window, optionally averaging 2^AVG_LOG2 windows into one published result.
// Ports:
//   fpga_clk1  in  : system clock (sole clock)
//   reset      in  : synchronous, active-high reset
//   enable     in  : 1 = measure continuously, 0 = return to / stay idle
//   avg_en     in  : averaging mode request, taken at the start of each batch
//   ring_in    in  : asynchronous ring-oscillator outputs, one per channel
//   sel        in  : channel shown on value_out
//   value_out  out : result[sel], or 0 when sel is not a valid channel
//   all_values out : every result, channel i at bits [i*CNT_W +: CNT_W]
//   valid      out : one-cycle pulse when results update
//   overflow   out : per-channel saturation flag of the last published result
//   busy       out : FSM is not idle
// -----------------------------------------------------------------------------
module multi_ring_counter import multi_ring_pkg::*; #(
    parameter int CH          = 4,
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 50000,
    parameter int AVG_LOG2    = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    fpga_clk1,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    avg_en,
    input  logic [CH-1:0]           ring_in,
    input  logic [sel_width(CH)-1:0] sel,
    output logic [CNT_W-1:0]        value_out,
    output logic [CH*CNT_W-1:0]     all_values,
    output logic                    valid,
    output logic [CH-1:0]           overflow,
    output logic                    busy
);

    localparam int GATE_W = gate_width(GATE_CYCLES);
    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int WIN_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'((1 << AVG_LOG2) - 1);

    state_t             state;
    logic [GATE_W-1:0]  gate_cnt;
    logic               avg_mode;
    logic [WIN_W-1:0]   win_idx;
    logic               batch_end;

    logic [CNT_W-1:0]   win_count [CH];
    logic [CH-1:0]      win_sat;
    logic [ACC_W-1:0]   acc       [CH];
    logic [ACC_W-1:0]   acc_sum   [CH];
    logic [CH-1:0]      batch_sat;
    logic [CNT_W-1:0]   result    [CH];

    logic               count_en;
    logic               win_clear;

    // Window counters only run in GATE; IDLE and LATCH hold them clear.
    assign count_en  = (state == GATE);
    assign win_clear = (state != GATE);
    assign busy      = (state != IDLE);

    // A batch is one window in plain mode, 2^AVG_LOG2 windows in averaging mode.
    assign batch_end = !avg_mode || (win_idx == WIN_LAST);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        ring_edge_counter #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk      (fpga_clk1),
            .reset    (reset),
            .ring     (ring_in[i]),
            .count_en (count_en),
            .clear    (win_clear),
            .count    (win_count[i]),
            .sat      (win_sat[i])
        );
    end

    // Running batch sum including the window that is being latched right now.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            acc_sum[i] = acc[i] + ACC_W'(win_count[i]);
        end
    end

    // Measurement FSM and gate timer. avg_mode is only re-taken when a new
    // batch begins so that a batch never mixes modes.
    always_ff @(posedge fpga_clk1) begin
        if (reset) begin
            state    <= IDLE;
            gate_cnt <= '0;
            avg_mode <= 1'b0;
            win_idx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    win_idx  <= '0;
                    if (enable) begin
                        state    <= GATE;
                        avg_mode <= avg_en;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        win_idx  <= '0;
                    end else if (gate_cnt == GATE_LAST) begin
                        state    <= LATCH;
                        gate_cnt <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    gate_cnt <= '0;
                    state    <= enable ? GATE : IDLE;
                    if (batch_end) begin
                        win_idx  <= '0;
                        avg_mode <= avg_en;
                    end else begin
                        win_idx <= win_idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result publishing and batch accumulation. An abort (enable low in GATE)
    // or idling discards the partial batch but leaves published results alone.
    always_ff @(posedge fpga_clk1) begin
        if (reset) begin
            valid     <= 1'b0;
            overflow  <= '0;
            batch_sat <= '0;
            for (int i = 0; i < CH; i++) begin
                result[i] <= '0;
                acc[i]    <= '0;
            end
        end else begin
            valid <= 1'b0;
            if (state == LATCH) begin
                if (!avg_mode) begin
                    valid    <= 1'b1;
                    overflow <= win_sat;
                    for (int i = 0; i < CH; i++) begin
                        result[i] <= win_count[i];
                    end
                end else if (batch_end) begin
                    valid     <= 1'b1;
                    overflow  <= batch_sat | win_sat;
                    batch_sat <= '0;
                    for (int i = 0; i < CH; i++) begin
                        result[i] <= acc_sum[i][ACC_W-1:AVG_LOG2];
                        acc[i]    <= '0;
                    end
                end else begin
                    batch_sat <= batch_sat | win_sat;
                    for (int i = 0; i < CH; i++) begin
                        acc[i] <= acc_sum[i];
                    end
                end
            end else if (state == IDLE || !enable) begin
                batch_sat <= '0;
                for (int i = 0; i < CH; i++) begin
                    acc[i] <= '0;
                end
            end
        end
    end

    // Output views of the result registers; sel outside 0..CH-1 reads as 0.
    always_comb begin
        value_out  = '0;
        all_values = '0;
        for (int i = 0; i < CH; i++) begin
            all_values[i*CNT_W +: CNT_W] = result[i];
            if (int'(sel) == i) begin
                value_out = result[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_ring_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_ring_counter
// Scoreboard bench: expected per-channel results are queued when ring periods
// are driven and popped when the DUT pulses valid.
// -----------------------------------------------------------------------------
module tb_multi_ring_counter;

    localparam int CH          = 3;
    localparam int CNT_W       = 8;
    localparam int GATE_CYCLES = 1000;
    localparam int AVG_LOG2    = 2;
    localparam int SYNC_STAGES = 2;
    localparam int SEL_W       = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                fpga_clk1 = 1'b0;
    logic                reset;
    logic                enable;
    logic                avg_en;
    logic [CH-1:0]       ring_in = '0;
    logic [SEL_W-1:0]    sel;
    logic [CNT_W-1:0]    value_out;
    logic [CH*CNT_W-1:0] all_values;
    logic                valid;
    logic [CH-1:0]       overflow;
    logic                busy;

    typedef struct {
        int ch;
        int lo;
        int hi;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_v;
    int   checks = 0;
    int   errors = 0;
    int   nvalid = 0;
    int   cyc = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;
    logic valid_d = 1'b0;
    int   per   [CH];
    int   phase [CH];
    int   last_lo [CH];
    int   last_hi [CH];
    int   t4, t5, tg, rst_at;

    multi_ring_counter #(
        .CH          (CH),
        .CNT_W       (CNT_W),
        .GATE_CYCLES (GATE_CYCLES),
        .AVG_LOG2    (AVG_LOG2),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .fpga_clk1  (fpga_clk1),
        .reset      (reset),
        .enable     (enable),
        .avg_en     (avg_en),
        .ring_in    (ring_in),
        .sel        (sel),
        .value_out  (value_out),
        .all_values (all_values),
        .valid      (valid),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 fpga_clk1 = ~fpga_clk1;

    always @(posedge fpga_clk1) cyc <= cyc + 1;

    // Ring oscillator models: one rising edge every per[i] clock cycles,
    // changing a little after the clock edge.
    always @(posedge fpga_clk1) begin
        #2;
        for (int i = 0; i < CH; i++) begin
            if (per[i] == 0) begin
                phase[i]   = 0;
                ring_in[i] = 1'b0;
            end else begin
                phase[i]   = (phase[i] + 1) % per[i];
                ring_in[i] = (phase[i] < per[i] / 2);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int nominal(input int p);
        int n;
        n = GATE_CYCLES / p;
        return (n > CNT_MAX) ? CNT_MAX : n;
    endfunction

    task automatic pushExp(input int ch, input int nom, input int slack, input bit ovf);
        exp_t e;
        e.ch  = ch;
        e.ovf = ovf;
        if (nom >= CNT_MAX) begin
            e.lo = CNT_MAX;
            e.hi = CNT_MAX;
        end else begin
            e.lo = nom - slack;
            e.hi = (nom + slack > CNT_MAX) ? CNT_MAX : nom + slack;
        end
        sb.push_back(e);
    endtask

    // Queue one plain-mode window worth of expectations for the current periods.
    task automatic pushWindow(input int slack);
        for (int i = 0; i < CH; i++) begin
            pushExp(i, nominal(per[i]), slack, (GATE_CYCLES / per[i]) > CNT_MAX);
        end
    endtask

    task automatic applyStimulus(input int p0, input int p1, input int p2);
        per[0] = p0;
        per[1] = p1;
        per[2] = p2;
    endtask

    task automatic waitValid(input int n, input int budget);
        int k;
        k = 0;
        while (nvalid < n && k < budget) begin
            @(negedge fpga_clk1);
            #1;
            k++;
        end
        if (nvalid < n) checkOutput($sformatf("timeout_valid%0d", n), nvalid, n);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) begin
            @(negedge fpga_clk1);
            #1;
        end
    endtask

    // Scoreboard: every valid pulse consumes one expectation per channel.
    always @(negedge fpga_clk1) begin
        if (valid === 1'b1) begin
            checkOutput("valid_single_cycle", valid_d, 0);
            nvalid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            for (int i = 0; i < CH; i++) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    mon_v = int'(all_values[mon_e.ch*CNT_W +: CNT_W]);
                    checkOutput($sformatf("result_ch%0d_%0d..%0d_got_%0d", mon_e.ch,
                                          mon_e.lo, mon_e.hi, mon_v),
                                (mon_v >= mon_e.lo && mon_v <= mon_e.hi), 1);
                    checkOutput($sformatf("overflow_ch%0d", mon_e.ch),
                                overflow[mon_e.ch], mon_e.ovf);
                    last_lo[mon_e.ch] = mon_e.lo;
                    last_hi[mon_e.ch] = mon_e.hi;
                end
            end
        end
        valid_d = valid;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < CH; i++) phase[i] = 0;
        reset  = 1'b1;
        enable = 1'b0;
        avg_en = 1'b0;
        sel    = '0;
        applyStimulus(10, 20, 3);

        // Reset with rings toggling
        repeat (3) @(posedge fpga_clk1);
        @(negedge fpga_clk1);
        #1;
        checkOutput("reset_value_out", value_out, 0);
        checkOutput("reset_all_values", all_values, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (2) @(negedge fpga_clk1);
        #1;
        checkOutput("idle_busy", busy, 0);

        // Plain counting, two identical windows
        pushWindow(1);
        pushWindow(1);
        enable = 1'b1;
        @(negedge fpga_clk1);
        #1;
        checkOutput("busy_after_enable", busy, 1);
        waitValid(1, 1100);
        waitValid(2, 1100);
        checkOutput("valid_interval_w2", last_valid_cyc - prev_valid_cyc, GATE_CYCLES + 1);

        // New periods; saturated channel 2 drops back to a small count
        applyStimulus(7, 25, 100);
        pushWindow(2);
        waitValid(3, 1100);
        checkOutput("valid_interval_w3", last_valid_cyc - prev_valid_cyc, GATE_CYCLES + 1);

        // Output mux sweep, including an out-of-range select
        for (int s = 0; s < 4; s++) begin
            @(negedge fpga_clk1);
            sel = SEL_W'(s);
            #1;
            if (s < CH) begin
                checkOutput($sformatf("mux_sel%0d_%0d..%0d_got_%0d", s, last_lo[s],
                                      last_hi[s], value_out),
                            (value_out >= last_lo[s] && value_out <= last_hi[s]), 1);
                checkOutput($sformatf("mux_vs_flat_sel%0d", s), value_out,
                            all_values[s*CNT_W +: CNT_W]);
            end else begin
                checkOutput("mux_sel_out_of_range", value_out, 0);
            end
        end

        // Request averaging; the window already running stays in plain mode
        avg_en = 1'b1;
        pushWindow(1);
        waitValid(4, 1100);
        t4 = last_valid_cyc;

        // Averaging batch: windows at periods 10,10,20,20 on channel 0
        applyStimulus(10, 10, 3);
        pushExp(0, (2 * nominal(10) + 2 * nominal(20)) >> AVG_LOG2, 2, 1'b0);
        pushExp(1, nominal(10), 2, 1'b0);
        pushExp(2, (4 * nominal(3)) >> AVG_LOG2, 0, 1'b1);
        waitUntil(t4 + (GATE_CYCLES + 1));
        checkOutput("avg_no_valid_win1", nvalid, 4);
        avg_en = 1'b0;
        waitUntil(t4 + 2 * (GATE_CYCLES + 1));
        checkOutput("avg_no_valid_win2", nvalid, 4);
        applyStimulus(20, 10, 3);
        waitUntil(t4 + 3 * (GATE_CYCLES + 1));
        checkOutput("avg_no_valid_win3", nvalid, 4);
        waitValid(5, 1100);
        checkOutput("avg_batch_interval", last_valid_cyc - t4, 4 * (GATE_CYCLES + 1));

        // Abort halfway through a plain window
        t5 = last_valid_cyc;
        sel = '0;
        waitUntil(t5 + 500);
        enable = 1'b0;
        repeat (2) @(negedge fpga_clk1);
        #1;
        checkOutput("abort_busy", busy, 0);
        repeat (20) @(negedge fpga_clk1);
        #1;
        checkOutput("abort_no_valid", nvalid, 5);
        checkOutput($sformatf("abort_keeps_result_%0d..%0d_got_%0d", last_lo[0], last_hi[0],
                              value_out),
                    (value_out >= last_lo[0] && value_out <= last_hi[0]), 1);
        checkOutput("abort_keeps_overflow2", overflow[2], 1);

        // Re-enable: first result one window plus latch after GATE entry
        pushWindow(1);
        enable = 1'b1;
        @(negedge fpga_clk1);
        #1;
        checkOutput("reenable_busy", busy, 1);
        tg = cyc;
        waitValid(6, 1100);
        checkOutput("reenable_latency", last_valid_cyc - tg, GATE_CYCLES + 1);

        // Reset in the middle of a window clears everything
        rst_at = cyc + 300;
        waitUntil(rst_at);
        reset = 1'b1;
        @(negedge fpga_clk1);
        #1;
        checkOutput("midrun_reset_value_out", value_out, 0);
        checkOutput("midrun_reset_all_values", all_values, 0);
        checkOutput("midrun_reset_overflow", overflow, 0);
        checkOutput("midrun_reset_busy", busy, 0);
        checkOutput("midrun_reset_valid", valid, 0);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_ring_counter.md
Name: multi_ring_counter

Overview:
Parametrised successor to the single-channel ring-oscillator counting circuit. It counts rising edges on CH ring-oscillator inputs at the same time, over a programmable gate window clocked by fpga_clk1. Per-window counts saturate, and an optional averaging mode combines 2^AVG_LOG2 windows into one result. A selected channel drives the 16-bit value path into SensorController; all results are also exposed flat for logging.

Parameters:
CH, 4, number of ring-oscillator channels (>=1)
CNT_W, 16, result / per-window counter width
GATE_CYCLES, 50000, gate window length in fpga_clk1 cycles (>=2)
AVG_LOG2, 3, averaging depth exponent; averaging mode uses 2^AVG_LOG2 windows
SYNC_STAGES, 2, synchroniser flops per ring input (>=2)

Ports:
fpga_clk1  in  1  system clock; sole clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = measure continuously; 0 = go to / stay in IDLE
avg_en  in  1  1 = averaging mode; sampled at the start of each batch
ring_in  in  CH  asynchronous ring-oscillator outputs
sel  in  max(1,$clog2(CH))  channel shown on value_out
value_out  out  CNT_W  result[sel]; 0 if sel>=CH
all_values  out  CH*CNT_W  result[i] at bits [i*CNT_W +: CNT_W]
valid  out  1  one-cycle pulse when results update
overflow  out  CH  per-channel saturation flag for the last published result
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all counters, accumulators and results 0; value_out 0; valid 0; overflow 0; busy 0.
- Per channel:
  - SYNC_STAGES-flop synchroniser, then an edge register; a rising edge is sync_out & ~prev.
  - Edge latency is SYNC_STAGES+1 cycles.
  - Input frequency must be below fpga_clk1/2; faster inputs alias (documented limitation, not detected).
- FSM: IDLE -> GATE -> LATCH -> (GATE | IDLE).
  - IDLE: gate_cnt=0, window counters 0. enable=1 moves to GATE next cycle and samples avg_en into avg_mode.
  - GATE: gate_cnt runs 0..GATE_CYCLES-1. An edge seen in any GATE cycle, including the last, increments that channel's window counter. The counter holds at 2^CNT_W-1 and sets the channel's sat bit. At gate_cnt==GATE_CYCLES-1, go to LATCH.
  - LATCH: one dead cycle; edges in it are dropped. Window counters and gate_cnt clear. Next state is GATE if enable=1, else IDLE.
- Publishing with avg_mode=0: on the edge leaving LATCH, result[i]=window count, overflow[i]=sat[i], and valid=1 for exactly the following cycle. Publish period is GATE_CYCLES+1 cycles.
- Publishing with avg_mode=1:
  - acc[i] is CNT_W+AVG_LOG2 bits wide and adds the window count at each LATCH; win_idx increments.
  - On the LATCH where win_idx==2^AVG_LOG2-1: result[i]=(acc[i]+count)>>AVG_LOG2 (truncating), overflow[i]=OR of sat over the batch, valid pulses, acc and win_idx clear.
  - Other windows produce no valid.
- avg_en is resampled only when a batch starts: at IDLE->GATE, at every LATCH in non-avg mode, and after the final window of an avg batch. Changes mid-batch are ignored.
- enable=0 during GATE: abort to IDLE next cycle. Counters, acc and win_idx clear. No valid is produced; results and overflow keep their previous values.
- enable=0 during LATCH: the publish completes, then the FSM goes to IDLE.
- reset=1 at any time: full reset next edge and overrides everything, including a valid due that cycle.
- value_out and all_values are combinational from the result registers. sel can change at any time, and value_out updates in the same cycle.

Decomposition:
- Package multi_ring_pkg: state enum (IDLE, GATE, LATCH), function computing GATE_W=$clog2(GATE_CYCLES), SEL_W helper.
- Sub-module ring_edge_counter (one instance per channel via generate): synchroniser, edge detect, saturating window counter with clear, sat flag.
- The top holds the FSM, gate counter, accumulators and result mux.

Test Plan:
1. Reset: assert reset 3 cycles with ring_in toggling -> value_out=0, valid=0, overflow=0, busy=0; busy=1 one cycle after enable=1.
2. Basic count: GATE_CYCLES=1000, ch0 period 10 cycles, ch1 period 20, avg_en=0 -> result0=100±1, result1=50±1; valid pulses exactly 1001 cycles apart.
3. Saturation: CNT_W=8, GATE_CYCLES=2000, ch2 period 4 -> result2=255, overflow[2]=1; next window at period 100 -> result2=20, overflow[2]=0.
4. Averaging: AVG_LOG2=2, GATE_CYCLES=1000, ch0 windows at periods 10,10,20,20 -> a single valid after the 4th LATCH with result0=75±1; no valid on windows 1-3.
5. Abort: drop enable at gate_cnt=500 -> no valid; busy=0 two cycles later; result keeps its prior value; re-enable -> the next valid arrives 1001 cycles after GATE entry.
6. Mux: distinct counts on 4 channels, sweep sel 0..3 -> value_out matches all_values slices in the same cycle; with CH=3, sel=3 -> value_out=0.
